// File: rtl/interrupt_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer.
//   state_t          : sequencer FSM state encoding
//   VEC_BASE_DEFAULT : default vector table base address
//   VEC_STRIDE       : spacing between consecutive vector entries
//   IRQ_ID_W         : width of the in-service line index
package interrupt_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_VECTOR  = 2'b01,
    ST_SERVICE = 2'b10,
    ST_RETURN  = 2'b11
  } state_t;

  localparam logic [7:0] VEC_BASE_DEFAULT = 8'hF0;
  localparam int         VEC_STRIDE       = 2;
  localparam int         IRQ_ID_W         = 2;

endpackage

// File: rtl/interrupt_sequencer_irq_priority_enc.sv
// Fixed-priority encoder: index 0 is the highest priority.
//   i_req   : qualified requests (pending & ~mask)
//   o_valid : at least one request present
//   o_idx   : lowest set index (0 when none)
module irq_priority_enc
  import interrupt_sequencer_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0]  i_req,
  output logic                o_valid,
  output logic [IRQ_ID_W-1:0] o_idx
);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    // Scan from the top down so the lowest set index is the last one written.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_idx   = IRQ_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Vectored interrupt sequencer for the 8-bit MIPS core.
// Edge-detects request lines into a pending register, masks and prioritises
// them, forces a one-cycle jump to the vector, and on reti forces a one-cycle
// jump back while strobing the saved flags out. No nesting.
//   clk, reset      : clock, asynchronous active-low reset
//   irq_req         : raw request levels, rising edge posts a request
//   mask_wr/data    : mask register write (bit=1 disables the line)
//   current_address : next fetch address, saved as the return address
//   flag_ex         : live flags, snapshotted at vector time
//   reti            : return-from-interrupt pulse (honoured in SERVICE only)
//   pc_mux_sel      : PC takes jmp_loc this cycle
//   jmp_loc         : vector address or return address
//   flag_restore    : one-cycle strobe qualifying flag_out
//   flag_out        : saved flags
//   int_active      : an interrupt is in service
//   irq_id          : index of the in-service line
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int                NUM_IRQ  = 4,
  parameter int                ADDR_W   = 8,
  parameter int                FLAG_W   = 4,
  parameter logic [ADDR_W-1:0] VEC_BASE = ADDR_W'(VEC_BASE_DEFAULT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  irq_req,
  input  logic                mask_wr,
  input  logic [NUM_IRQ-1:0]  mask_data,
  input  logic [ADDR_W-1:0]   current_address,
  input  logic [FLAG_W-1:0]   flag_ex,
  input  logic                reti,
  output logic                pc_mux_sel,
  output logic [ADDR_W-1:0]   jmp_loc,
  output logic                flag_restore,
  output logic [FLAG_W-1:0]   flag_out,
  output logic                int_active,
  output logic [IRQ_ID_W-1:0] irq_id
);

  state_t              r_state;
  state_t              w_next_state;
  logic [NUM_IRQ-1:0]  r_prev;
  logic [NUM_IRQ-1:0]  r_pending;
  logic [NUM_IRQ-1:0]  r_mask;
  logic [ADDR_W-1:0]   r_saved_addr;
  logic [FLAG_W-1:0]   r_saved_flags;
  logic [FLAG_W-1:0]   r_flag_out;
  logic [IRQ_ID_W-1:0] r_irq_id;

  logic                w_valid;
  logic [IRQ_ID_W-1:0] w_idx;
  logic                w_take;
  logic [NUM_IRQ-1:0]  w_rise;
  logic [NUM_IRQ-1:0]  w_clr;
  logic [ADDR_W-1:0]   w_vec;

  // Arbitration sees the mask as it was before any write on this edge.
  irq_priority_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .i_req   (r_pending & ~r_mask),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  assign w_take = (r_state == ST_IDLE) && w_valid;
  assign w_rise = irq_req & ~r_prev;
  assign w_clr  = w_take ? (NUM_IRQ'(1) << w_idx) : '0;
  assign w_vec  = VEC_BASE + ADDR_W'(r_irq_id) * ADDR_W'(VEC_STRIDE);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:    if (w_valid) w_next_state = ST_VECTOR;
      ST_VECTOR:  w_next_state = ST_SERVICE;
      ST_SERVICE: if (reti) w_next_state = ST_RETURN;
      ST_RETURN:  w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev        <= '0;
      r_pending     <= '0;
      r_mask        <= '1;
      r_saved_addr  <= '0;
      r_saved_flags <= '0;
      r_flag_out    <= '0;
      r_irq_id      <= '0;
    end else begin
      r_prev    <= irq_req;
      // A new edge on the line being vectored survives the clear.
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (mask_wr) r_mask <= mask_data;
      if (w_take) begin
        r_saved_addr  <= current_address;
        r_saved_flags <= flag_ex;
        r_irq_id      <= w_idx;
      end
      // flag_out only changes on entry to RETURN and holds afterwards.
      if (r_state == ST_SERVICE && reti) r_flag_out <= r_saved_flags;
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    pc_mux_sel   = 1'b0;
    jmp_loc      = '0;
    flag_restore = 1'b0;
    int_active   = (r_state != ST_IDLE);
    case (r_state)
      ST_VECTOR: begin
        pc_mux_sel = 1'b1;
        jmp_loc    = w_vec;
      end
      ST_RETURN: begin
        pc_mux_sel   = 1'b1;
        jmp_loc      = r_saved_addr;
        flag_restore = 1'b1;
      end
      default: ;
    endcase
  end

  assign flag_out = r_flag_out;
  assign irq_id   = r_irq_id;

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Vectored interrupt controller for the 8-bit MIPS core. It sits beside the jump-control path and drives the interrupt side of the PC mux.
- Edge-detects up to 4 interrupt request lines, holds them as pending, and masks and prioritises them.
- Forces a one-cycle jump to a vector address, saving the return address and the flag_ex snapshot.
- On return-from-interrupt it restores both. Only one interrupt is in service at a time; there is no nesting.

Parameters:
NUM_IRQ, 4, number of request lines (index 0 = highest priority)
ADDR_W, 8, instruction address width
FLAG_W, 4, execution flag width
VEC_BASE, 8'hF0, vector table base; vector(i) = VEC_BASE + 2*i

Ports:
clk  input  1  system clock; all logic is rising-edge
reset  input  1  asynchronous, active-low reset
irq_req  input  NUM_IRQ  raw level requests; a rising edge posts a request
mask_wr  input  1  write strobe for the mask register
mask_data  input  NUM_IRQ  new mask value; bit=1 disables that line
current_address  input  ADDR_W  address of the next instruction the core would fetch
flag_ex  input  FLAG_W  live execution flags
reti  input  1  one-cycle pulse from the decoder on return-from-interrupt
pc_mux_sel  output  1  1 = PC takes jmp_loc this cycle
jmp_loc  output  ADDR_W  vector address or return address
flag_restore  output  1  1-cycle strobe: flag_out must be loaded into the flag register
flag_out  output  FLAG_W  saved flags
int_active  output  1  high while an interrupt is in service
irq_id  output  2  index of the in-service line

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - state to IDLE; pending, saved_addr, saved_flags and edge-detect history to 0; mask to all ones (all lines disabled).
  - outputs pc_mux_sel=0, jmp_loc=0, flag_restore=0, flag_out=0, int_active=0, irq_id=0.
  - Reset mid-service abandons the interrupt and does not restore flags.
- Edge detect:
  - pending[i] is set on the cycle irq_req[i] is 1 after being 0 on the previous cycle.
  - A bit is cleared only when that line is vectored.
  - Set and clear of the same bit in the same cycle: set wins.
- Mask:
  - mask_wr loads mask at the clock edge.
  - Arbitration in that same cycle uses the old mask.
  - Masked lines remain pending.
- States:
  - IDLE: if any bit of (pending & ~mask) is set, select the lowest index i, latch saved_addr=current_address, saved_flags=flag_ex, irq_id=i, clear pending[i], and go to VECTOR. Otherwise stay in IDLE.
  - VECTOR (exactly 1 cycle): pc_mux_sel=1, jmp_loc=VEC_BASE+2*irq_id (mod 2^ADDR_W), int_active=1, then go to SERVICE.
  - SERVICE: int_active=1 and pc_mux_sel=0. New requests only accumulate in pending. reti=1 goes to RETURN.
  - RETURN (exactly 1 cycle): pc_mux_sel=1, jmp_loc=saved_addr, flag_restore=1, flag_out=saved_flags, int_active=1, then go to IDLE.
- Latency: qualifying edge sampled at edge N → VECTOR outputs visible during cycle N+1 → SERVICE from N+2.
- reti outside SERVICE is ignored.
- A request pending at RETURN is vectored at the earliest from the IDLE cycle after RETURN, so there is always at least one IDLE cycle between interrupts.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- flag_out holds its value outside RETURN; flag_restore qualifies it.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'b00, VECTOR=2'b01, SERVICE=2'b10, RETURN=2'b11.
  - VEC_BASE default.
  - vector stride constant 2.
- One sub-module: irq_priority_enc. It is combinational and takes (pending & ~mask) in, giving a valid bit and a 2-bit lowest-index out.
- Edge detect, pending, saved registers and FSM stay in the top module.

Test Plan:
- Reset held low, toggle irq_req → all outputs 0, mask=4'hF, no pending, no vector.
- mask_data=4'h0 via mask_wr, then irq_req[2] 0→1 with current_address=8'h04 and flag_ex=4'h8 → one cycle later pc_mux_sel=1, jmp_loc=8'hF4, irq_id=2, then int_active=1. A reti pulse then gives RETURN with jmp_loc=8'h04, flag_out=4'h8, flag_restore=1 for one cycle.
- irq_req[3] and irq_req[1] rising in the same cycle, mask 4'h0 → vector 8'hF2 first. After reti and one IDLE cycle → vector 8'hF6.
- mask=4'hF, irq_req[0] rising → no vector and pending[0] stays set. Write mask 4'hE → vector 8'hF0 on the cycle after the write takes effect.
- irq_req[1] held high across several cycles → exactly one vector. A reti in IDLE → no output change.
- reset asserted in SERVICE → int_active=0 and no flag_restore. After release the previously pending line does not vector because mask=4'hF.
